bin_to_bcd: RTL and testbench

//  Sequential double-dabble converter: turns a WIDTH-bit binary value (e.g. the
//  8b computer's output register) into DIGITS packed BCD nibbles.

---
 rtl/bin_to_bcd.sv | 111 +++++++++++
 tb/tb_bin_to_bcd.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble binary -> packed BCD converter.
// One operand per start/busy/done handshake; bcd holds the last result.
// Optional build macro BIN_TO_BCD_SIGNED_EN: treat bin as two's complement,
// convert its magnitude and report the sign on neg.
module bin_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                r_state, w_next;
  logic [SW-1:0]         r_scr, w_adj, w_shl;
  logic [CW-1:0]         r_cnt;
  logic                  w_accept;
  logic [WIDTH-1:0]      w_oper;
  logic                  r_busy, r_done;
  logic [4*DIGITS-1:0]   r_bcd;

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

`ifdef BIN_TO_BCD_SIGNED_EN
  logic r_neg_pend, r_neg;
  // Most negative input wraps to 2**(WIDTH-1), which is the right magnitude.
  assign w_oper = bin[WIDTH-1] ? -bin : bin;
  assign neg    = r_neg;

  // Sign captured with the operand, published together with bcd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_pend <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      if (w_accept)         r_neg_pend <= bin[WIDTH-1];
      if (r_state == DONE)  r_neg      <= r_neg_pend;
    end
  end
`else
  assign w_oper = bin;
  assign neg    = 1'b0;
`endif

  // All BCD nibbles adjusted in parallel; binary part passes through.
  assign w_adj[WIDTH-1:0] = r_scr[WIDTH-1:0];
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_adj[WIDTH+4*g +: 4] = (r_scr[WIDTH+4*g +: 4] >= 4'd5) ?
                                   r_scr[WIDTH+4*g +: 4] + 4'd3 :
                                   r_scr[WIDTH+4*g +: 4];
  end
  // Carry out of the top digit falls off the end.
  assign w_shl = w_adj << 1;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and operand acceptance; start only honoured in IDLE/DONE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE:  if (start) begin w_accept = 1'b1; w_next = SHIFT; end
      SHIFT: if (r_cnt == LAST) w_next = DONE;
      DONE:  begin
        if (start) begin w_accept = 1'b1; w_next = SHIFT; end
        else             w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Scratch/counter datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scr  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bcd  <= '0;
    end else begin
      r_busy <= (w_next == SHIFT);
      r_done <= (r_state == DONE);
      if (r_state == DONE) r_bcd <= r_scr[SW-1:WIDTH];
      if (w_accept) begin
        r_scr <= {{(4*DIGITS){1'b0}}, w_oper};
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_scr <= w_shl;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: directed vectors with hand-computed BCD results.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  bin;
  logic        busy, done, neg;
  logic [11:0] bcd;

  int n_chk = 0;
  int n_err = 0;

  bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accept one operand, scramble bin afterwards, wait (bounded) for done.
  task automatic conv(input string tag, input logic [7:0] v,
                      input logic [11:0] exp_bcd, input logic exp_neg);
    int lat;
    start = 1'b1; bin = v;
    tick();
    start = 1'b0; bin = ~v;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (lat < 20) begin
      tick(); lat++;
      if (done) break;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    chk({tag, "_neg"}, 32'(neg), 32'(exp_neg));
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; bin = 8'h00;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd",  32'(bcd),  32'h000);
    chk("rst_neg",  32'(neg),  32'd0);
    rst = 1'b0;
    tick();

`ifdef BIN_TO_BCD_SIGNED_EN
    conv("ff", 8'hFF, 12'h001, 1'b1);
    conv("80", 8'h80, 12'h128, 1'b1);
    conv("7f", 8'h7F, 12'h127, 1'b0);
    conv("f6", 8'hF6, 12'h010, 1'b1);
`else
    conv("ff", 8'hFF, 12'h255, 1'b0);
    conv("80", 8'h80, 12'h128, 1'b0);
    conv("7f", 8'h7F, 12'h127, 1'b0);
`endif
    conv("00",  8'h00,  12'h000, 1'b0);
    conv("99",  8'd99,  12'h099, 1'b0);
    conv("100", 8'd100, 12'h100, 1'b0);

    // Result held between conversions, done is a single pulse.
    tick(); tick(); tick();
    chk("hold_bcd",  32'(bcd),  32'h100);
    chk("hold_done", 32'(done), 32'd0);
    chk("hold_busy", 32'(busy), 32'd0);

    // start during SHIFT ignored; start in DONE accepted with no gap.
    start = 1'b1; bin = 8'd42;
    tick();                                 // edge N
    start = 1'b0; bin = 8'd0;
    tick(); tick();                         // after N+2
    start = 1'b1; bin = 8'd7;
    tick();                                 // N+3: must be ignored
    start = 1'b0; bin = 8'd0;
    tick(); tick(); tick(); tick(); tick(); // after N+8: DONE state
    chk("b2b_nodone_yet", 32'(done), 32'd0);
    start = 1'b1; bin = 8'd7;
    tick();                                 // N+9: accept second operand
    start = 1'b0; bin = 8'hAA;
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_bcd1",  32'(bcd),  32'h042);
    chk("b2b_busy",  32'(busy), 32'd1);
    ndone = 0;
    while (ndone < 20) begin
      tick(); ndone++;
      if (done) break;
    end
    chk("b2b_lat2", 32'(ndone), 32'd9);
    chk("b2b_bcd2", 32'(bcd),   32'h007);

    // Reset mid-conversion aborts it and clears outputs immediately.
    tick();
    start = 1'b1; bin = 8'd200;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd",  32'(bcd),  32'h000);
    chk("abort_neg",  32'(neg),  32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_quiet", 32'(ndone), 32'd0);
    chk("abort_bcd_held", 32'(bcd), 32'h000);
    conv("after_rst", 8'd123, 12'h123, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
